// File: rtl/alu_mc.sv
// alu_mc: registered, multi-cycle ALU with start/busy/done handshake.
// Single-cycle ops (add/sub/neg/pass/and/or/xor) finish at the accepting
// edge. Unsigned multiply runs as W shift-add steps. Result and flags hold
// until the next completed operation.
module alu_mc #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] R,
  output logic         zero,
  output logic         carry,
  output logic         sign,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  localparam logic [CW-1:0] CNT_W   = CW'(W);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [W:0]    EXT_ONE = (W + 1)'(1);
  localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_PASS = 3'b010,
    OP_NEG  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_MUL  = 3'b111
  } op_e;

  // Control and result registers
  state_t          state_q;
  logic [W-1:0]    r_q;
  logic            zero_q;
  logic            carry_q;
  logic            sign_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right
  logic [2*W-1:0]  mcand_q;
  logic [W-1:0]    mplier_q;
  logic [2*W-1:0]  acc_q;
  logic [2*W-1:0]  acc_d;
  logic [CW-1:0]   cnt_q;

  // Single-cycle ALU results
  op_e             op_sel;
  logic [W:0]      sum_ext;
  logic [W-1:0]    alu_r;
  logic            alu_c;
  logic            alu_v;

  // Value written into R/flags on a completing edge
  logic            commit;
  logic [W-1:0]    commit_r;
  logic            commit_c;
  logic            commit_v;

  assign op_sel = op_e'(op);

  // Combinational single-cycle result for the op presented on the inputs
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case leaves one unassigned and infers a latch.
    sum_ext = '0;
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op_sel)
      OP_ADD: begin
        sum_ext = {1'b0, A} + {1'b0, B};
        alu_r   = sum_ext[W-1:0];
        alu_c   = sum_ext[W];
        alu_v   = (A[W-1] == B[W-1]) && (alu_r[W-1] != A[W-1]);
      end
      OP_SUB: begin
        // carry = 1 means no borrow
        sum_ext = {1'b0, A} + {1'b0, ~B} + EXT_ONE;
        alu_r   = sum_ext[W-1:0];
        alu_c   = sum_ext[W];
        alu_v   = (A[W-1] != B[W-1]) && (alu_r[W-1] != A[W-1]);
      end
      OP_NEG: begin
        sum_ext = {1'b0, ~A} + EXT_ONE;
        alu_r   = sum_ext[W-1:0];
        alu_c   = sum_ext[W];
        alu_v   = (A == MIN_NEG);
      end
      OP_PASS: alu_r = A;
      OP_AND:  alu_r = A & B;
      OP_OR:   alu_r = A | B;
      OP_XOR:  alu_r = A ^ B;
      OP_MUL:  alu_r = '0;  // handled by the iterative datapath
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Select what (if anything) is written to R and the flags this edge
  always_comb begin
    commit   = 1'b0;
    commit_r = alu_r;
    commit_c = alu_c;
    commit_v = alu_v;
    if (state_q == IDLE) begin
      commit = start && (op_sel != OP_MUL);
    end else if (cnt_q == CNT_ONE) begin
      // last step: acc_d already holds the full 2W-bit product
      commit   = 1'b1;
      commit_r = acc_d[W-1:0];
      commit_c = |acc_d[2*W-1:W];
      commit_v = |acc_d[2*W-1:W];
    end
  end

  // Handshake FSM, multiplier iteration and registered result/flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: datapath registers are reset along with control so an aborted multiply leaves no stale partial product.
      state_q  <= IDLE;
      r_q      <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples the pre-edge values of the others.
      done_q <= commit;
      if (commit) begin
        r_q     <= commit_r;
        zero_q  <= (commit_r == '0);
        sign_q  <= commit_r[W-1];
        carry_q <= commit_c;
        ovf_q   <= commit_v;
      end

      unique case (state_q)
        IDLE: begin
          if (start && (op_sel == OP_MUL)) begin
            mcand_q  <= {{W{1'b0}}, A};
            mplier_q <= B;
            acc_q    <= '0;
            cnt_q    <= CNT_W;
            busy_q   <= 1'b1;
            state_q  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign R        = r_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign sign     = sign_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed scoreboard bench for alu_mc at W=4 and W=8.
// Expected results come from an integer reference model, pushed on issue
// and popped when the DUT pulses done.
module tb_alu_mc;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       s;
    logic       v;
  } exp_t;

  localparam exp_t RST_VAL = {8'd0, 1'b1, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start4, start8;
  logic [2:0] op;
  logic [7:0] a_in, b_in;

  logic [3:0] r4;
  logic       z4, c4, s4, v4, busy4, done4;
  logic [7:0] r8;
  logic       z8, c8, s8, v8, busy8, done8;

  int   cur_w = 4;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  exp_t obs;
  logic obs_busy, obs_done;

  always #5 clk = ~clk;

  alu_mc #(.W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op(op),
    .A(a_in[3:0]), .B(b_in[3:0]), .R(r4), .zero(z4), .carry(c4),
    .sign(s4), .overflow(v4), .busy(busy4), .done(done4)
  );

  alu_mc #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op),
    .A(a_in), .B(b_in), .R(r8), .zero(z8), .carry(c8),
    .sign(s8), .overflow(v8), .busy(busy8), .done(done8)
  );

  // Observe whichever DUT is currently under test
  always_comb begin
    if (cur_w == 8) begin
      obs      = {r8, z8, c8, s8, v8};
      obs_busy = busy8;
      obs_done = done8;
    end else begin
      obs      = {4'd0, r4, z4, c4, s4, v4};
      obs_busy = busy4;
      obs_done = done4;
    end
  end

  // Reference model in plain integer arithmetic
  function automatic exp_t model(input logic [2:0] f, input int a, input int b, input int w);
    exp_t e;
    int   m, half, full, sa, sbv, sr;
    e    = '0;
    m    = 1 << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sbv  = (b >= half) ? b - m : b;
    full = 0;
    case (f)
      3'd0: begin
        full = a + b;
        e.c  = (full >= m);
        sr   = sa + sbv;
        e.v  = (sr >= half) || (sr < -half);
      end
      3'd1: begin
        full = a - b + m;
        e.c  = (a >= b);
        sr   = sa - sbv;
        e.v  = (sr >= half) || (sr < -half);
      end
      3'd2: full = a;
      3'd3: begin
        full = m - a;
        e.c  = (a == 0);
        e.v  = (a == half);
      end
      3'd4: full = a & b;
      3'd5: full = a | b;
      3'd6: full = a ^ b;
      default: begin
        full = a * b;
        e.c  = (full >= m);
        e.v  = (full >= m);
      end
    endcase
    e.r = 8'(full % m);
    e.z = (e.r == 8'd0);
    e.s = e.r[w-1];
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    op   = f;
    a_in = a;
    b_in = b;
    if (cur_w == 8) start8 = 1'b1;
    else            start4 = 1'b1;
    sb.push_back(model(f, int'(a), int'(b), cur_w));
  endtask

  task automatic drop_start;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Called in a cycle where done should be high: pop and compare
  task automatic expect_done(input string tag);
    exp_t e;
    check({tag, ".done"}, 16'(obs_done), 16'd1);
    check({tag, ".busy"}, 16'(obs_busy), 16'd0);
    check({tag, ".sb"}, 16'(sb.size()), 16'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".res"}, 16'(obs), 16'(e));
    end
  endtask

  task automatic single(input string tag, input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    issue(f, a, b);
    step;
    drop_start;
    expect_done(tag);
  endtask

  // Multiply: checks held outputs during the run and exact W-edge latency;
  // optionally presents an ADD request mid-run that must be ignored.
  task automatic mul(input string tag, input logic [7:0] a, input logic [7:0] b, input bit inject);
    exp_t held;
    int   n;
    held = obs;
    issue(3'b111, a, b);
    step;
    drop_start;
    n = 0;
    while (obs_busy && n < 40) begin
      check({tag, ".hold"}, 16'(obs), 16'(held));
      check({tag, ".nodone"}, 16'(obs_done), 16'd0);
      if (inject && n == 1) begin
        op   = 3'b000;
        a_in = 8'd1;
        b_in = 8'd1;
        if (cur_w == 8) start8 = 1'b1;
        else            start4 = 1'b1;
      end
      step;
      drop_start;
      n++;
    end
    check({tag, ".lat"}, 16'(n), 16'(cur_w));
    expect_done(tag);
  endtask

  initial begin
    int seen_done;
    drop_start;
    op   = 3'd0;
    a_in = 8'd0;
    b_in = 8'd0;
    #1 reset = 1'b1;
    #2;
    cur_w = 4;
    #1;
    check("rst4.res", 16'(obs), 16'(RST_VAL));
    check("rst4.busy", 16'(obs_busy), 16'd0);
    check("rst4.done", 16'(obs_done), 16'd0);
    cur_w = 8;
    #1;
    check("rst8.res", 16'(obs), 16'(RST_VAL));
    cur_w = 4;
    #18 reset = 1'b0;
    step;

    // Single-cycle ops, issued back to back
    single("add_7_9", 3'd0, 8'd7, 8'd9);
    step;
    check("add_7_9.fall", 16'(obs_done), 16'd0);
    check("add_7_9.held", 16'(obs.r), 16'd0);
    single("add_7_1", 3'd0, 8'd7, 8'd1);
    single("sub_3_5", 3'd1, 8'd3, 8'd5);
    single("neg_8",   3'd3, 8'd8, 8'd0);
    single("neg_0",   3'd3, 8'd0, 8'd0);
    single("sub_9_9", 3'd1, 8'd9, 8'd9);
    single("pass_9",  3'd2, 8'd9, 8'd3);
    single("and",     3'd4, 8'hC, 8'hA);
    single("or",      3'd5, 8'h5, 8'h2);
    single("xor",     3'd6, 8'hF, 8'h5);
    step;

    // Multiply, with a request injected mid-run and a back-to-back ADD
    mul("mul_5_3", 8'd5, 8'd3, 1'b0);
    step;
    mul("mul_6_7", 8'd6, 8'd7, 1'b1);
    single("b2b_add", 3'd0, 8'd4, 8'd5);
    step;
    mul("mul_0_9", 8'd0, 8'd9, 1'b0);
    single("pre_rst", 3'd0, 8'd3, 8'd3);

    // Asynchronous reset two edges into a multiply
    op     = 3'b111;
    a_in   = 8'd7;
    b_in   = 8'd7;
    start4 = 1'b1;
    step;
    drop_start;
    step;
    step;
    #3 reset = 1'b1;
    #1;
    check("midrst.res", 16'(obs), 16'(RST_VAL));
    check("midrst.busy", 16'(obs_busy), 16'd0);
    check("midrst.done", 16'(obs_done), 16'd0);
    step;
    #3 reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (obs_done) seen_done++;
    end
    check("midrst.nopulse", 16'(seen_done), 16'd0);
    single("post_rst", 3'd0, 8'd2, 8'd3);
    step;

    // W=8 instance
    cur_w = 8;
    #1;
    mul("w8_mul_ff", 8'hFF, 8'hFF, 1'b0);
    single("w8_xor_aa", 3'd6, 8'hAA, 8'hAA);
    single("w8_add_80", 3'd0, 8'h80, 8'h80);
    step;
    mul("w8_mul_16", 8'd16, 8'd16, 1'b0);
    step;

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, registered, multi-cycle successor to the 4-bit combinational ALU.
- Accepts an operation via a start/busy/done handshake.
- Executes add/sub/neg/pass/logic ops in one cycle and unsigned multiply iteratively (shift-add, W cycles).
- Holds result and flags (zero, carry, sign, overflow) in registers until the next completed operation.
- Sits between the register file and the accumulator/flag logic of the datapath.

Parameters:
W, 4, operand/result width in bits (W >= 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  000 ADD, 001 SUB, 010 PASS A, 011 NEG A, 100 AND, 101 OR, 110 XOR, 111 MUL
A  input  W  operand 1
B  input  W  operand 2
R  output  W  registered result
zero  output  1  R == 0
carry  output  1  carry-out / multiply high-part-nonzero
sign  output  1  R[W-1]
overflow  output  1  signed overflow
busy  output  1  operation in progress; start ignored
done  output  1  one-cycle pulse: R/flags just updated

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: R=0, zero=1, carry=0, sign=0, overflow=0, busy=0, done=0, state=IDLE, iteration counter=0.
- States: IDLE, MUL_RUN.
- Operand capture: op, A and B are captured at the accepting edge. Later input changes have no effect on the operation in flight.
- Single-cycle ops (op != 111): start=1 in IDLE at edge k writes R and flags at edge k. done=1 for the cycle after edge k. State stays IDLE, busy stays 0.
- MUL, load: start=1 with op=111 in IDLE at edge k loads multiplicand, multiplier and a 2W-bit accumulator=0, counter=W, and enters MUL_RUN. busy=1 from edge k.
- MUL, iterate: each MUL_RUN edge does one shift-add step and decrements the counter.
- MUL, complete: at the edge where the counter reaches 0 (edge k+W), R, flags and done are written, busy clears and state returns to IDLE.
- done: one cycle wide, deasserts at the next edge unless a new single-cycle op completes.
- Back-to-back: start in the cycle done=1 with busy=0 is accepted.
- start while busy=1: ignored, not queued.
- Outputs between operations: R and flags hold their last values. During MUL_RUN, R and flags keep the previous op's values.
- ADD: {carry,R} = A + B. overflow = (A[W-1]==B[W-1]) & (R[W-1]!=A[W-1]).
- SUB: {carry,R} = A + ~B + 1, so carry=1 means no borrow. overflow = (A[W-1]!=B[W-1]) & (R[W-1]!=A[W-1]).
- NEG: {carry,R} = 0 + ~A + 1. overflow = (A == 1 followed by W-1 zeros).
- PASS, AND, OR, XOR: R = result; carry=0, overflow=0.
- MUL: unsigned 2W-bit product P. R = P[W-1:0]. carry = overflow = |P[2W-1:W].
- All ops: zero = (R==0), sign = R[W-1], computed from the new R.
- Undefined op encodings: none, since all 8 codes are defined.
- Reset mid-MUL: immediate return to reset values; the partial product is discarded and done is never pulsed for the aborted op.

Test Plan (W=4 unless stated):
- ADD A=7 B=9 -> after 1 edge: R=0, zero=1, carry=1, sign=0, overflow=0, done pulse 1 cycle, busy stays 0.
- ADD A=7 B=1 -> R=8, sign=1, overflow=1, carry=0. SUB A=3 B=5 -> R=14, carry=0, sign=1, overflow=0. NEG A=8 -> R=8, overflow=1.
- MUL A=5 B=3 -> busy=1 for 4 cycles; R=15, carry=0, overflow=0, sign=1. done at edge k+4 exactly; R/flags unchanged during MUL_RUN.
- MUL A=6 B=7 -> R=10, carry=1, overflow=1. start with op=ADD asserted mid-run -> ignored; final R=10. Back-to-back ADD on the done cycle -> accepted.
- Reset asserted 2 cycles into MUL (async, mid-cycle) -> all outputs at reset values immediately, no done pulse. Next op executes normally.
- W=8: MUL A=255 B=255 -> R=1, carry=1 after 8 cycles. XOR A=0xAA B=0xAA -> R=0, zero=1, carry=0.
